// File: rtl/mem_arbiter_if.sv
// Request/response and memory-port bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        if_resp_err;

  logic        lsu_req_valid;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_we;
  logic [1:0]  lsu_req_size;
  logic [31:0] lsu_req_wdata;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        lsu_resp_err;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    input  lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_size, lsu_req_wdata,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    output mem_address, mem_write_data, mem_write_enable,
    input  mem_read_data
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    output lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_size, lsu_req_wdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    input  mem_address, mem_write_data, mem_write_enable,
    output mem_read_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IF and LSU onto one word-wide memory with registered reads;
// sub-word stores become read-modify-write, illegal accesses get an error response.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;
  typedef enum logic {GNT_IF, GNT_LSU} grant_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);
  localparam logic [1:0]  SIZE_BYTE  = 2'b00;
  localparam logic [1:0]  SIZE_HALF  = 2'b01;
  localparam logic [1:0]  SIZE_WORD  = 2'b10;

  state_t      state, state_next;
  grant_t      last_grant, last_grant_next;
  grant_t      owner, owner_next;
  logic        err_q, err_next;
  logic        rd_q, rd_next;
  logic [31:0] addr_q, addr_next;
  logic [1:0]  size_q, size_next;
  logic [15:0] wdata_q, wdata_next;

  grant_t      grant;
  logic        accept;
  logic        if_err, lsu_err, lsu_misalign;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_err, req_store;

  // Little-endian lane insert of the latched store data into the old word.
  function automatic logic [31:0] merge_word(input logic [31:0] old,
                                             input logic [15:0] wd,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] w;
    w = old;
    if (size == SIZE_BYTE) begin
      case (lane)
        2'd0: w[7:0]   = wd[7:0];
        2'd1: w[15:8]  = wd[7:0];
        2'd2: w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      w[31:16] = wd;
    end else begin
      w[15:0] = wd;
    end
    return w;
  endfunction

  always_comb begin
    if (bus.if_req_valid && bus.lsu_req_valid)
      grant = (last_grant == GNT_IF) ? GNT_LSU : GNT_IF;
    else
      grant = bus.lsu_req_valid ? GNT_LSU : GNT_IF;
  end

  assign accept = reset_n && (state == IDLE) && (bus.if_req_valid || bus.lsu_req_valid);
  assign bus.if_req_ready  = accept && (grant == GNT_IF);
  assign bus.lsu_req_ready = accept && (grant == GNT_LSU);

  always_comb begin
    case (bus.lsu_req_size)
      SIZE_BYTE: lsu_misalign = 1'b0;
      SIZE_HALF: lsu_misalign = bus.lsu_req_addr[0];
      SIZE_WORD: lsu_misalign = (bus.lsu_req_addr[1:0] != 2'b00);
      default:   lsu_misalign = 1'b1;
    endcase
  end

  assign if_err  = (bus.if_req_addr[1:0] != 2'b00) || (bus.if_req_addr >= ADDR_LIMIT);
  assign lsu_err = lsu_misalign || (bus.lsu_req_addr >= ADDR_LIMIT);

  assign req_addr  = (grant == GNT_LSU) ? bus.lsu_req_addr : bus.if_req_addr;
  assign req_size  = (grant == GNT_LSU) ? bus.lsu_req_size : SIZE_WORD;
  assign req_err   = (grant == GNT_LSU) ? lsu_err : if_err;
  assign req_store = (grant == GNT_LSU) && bus.lsu_req_we;

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next           = state;
    last_grant_next      = last_grant;
    owner_next           = owner;
    err_next             = err_q;
    rd_next              = rd_q;
    addr_next            = addr_q;
    size_next            = size_q;
    wdata_next           = wdata_q;
    bus.mem_address      = {addr_q[31:2], 2'b00};
    bus.mem_write_data   = 32'h0;
    bus.mem_write_enable = 1'b0;
    bus.if_resp_valid    = 1'b0;
    bus.if_resp_data     = 32'h0;
    bus.if_resp_err      = 1'b0;
    bus.lsu_resp_valid   = 1'b0;
    bus.lsu_resp_data    = 32'h0;
    bus.lsu_resp_err     = 1'b0;

    case (state)
      IDLE: begin
        bus.mem_address = {req_addr[31:2], 2'b00};
        if (accept) begin
          owner_next      = grant;
          last_grant_next = grant;
          addr_next       = req_addr;
          size_next       = req_size;
          wdata_next      = bus.lsu_req_wdata[15:0];
          err_next        = req_err;
          rd_next         = !req_err && !req_store;
          state_next      = RESP;
          if (!req_err && req_store) begin
            // Full words go straight in; narrower stores read the word first.
            if (req_size == SIZE_WORD) begin
              bus.mem_write_data   = bus.lsu_req_wdata;
              bus.mem_write_enable = 1'b1;
            end else begin
              state_next = MERGE;
            end
          end
        end
      end
      MERGE: begin
        bus.mem_write_data   = merge_word(bus.mem_read_data, wdata_q, addr_q[1:0], size_q);
        bus.mem_write_enable = reset_n;
        state_next           = RESP;
      end
      RESP: begin
        if (reset_n) begin
          if (owner == GNT_IF) begin
            bus.if_resp_valid = 1'b1;
            bus.if_resp_err   = err_q;
            bus.if_resp_data  = rd_q ? bus.mem_read_data : 32'h0;
          end else begin
            bus.lsu_resp_valid = 1'b1;
            bus.lsu_resp_err   = err_q;
            bus.lsu_resp_data  = rd_q ? bus.mem_read_data : 32'h0;
          end
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GNT_IF;
      owner      <= GNT_IF;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= 32'h0;
      size_q     <= 2'b00;
      wdata_q    <= 16'h0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      owner      <= owner_next;
      err_q      <= err_next;
      rd_q       <= rd_next;
      addr_q     <= addr_next;
      size_q     <= size_next;
      wdata_q    <= wdata_next;
    end
  end

endmodule
